imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Two-stage pipelined immediate/offset generator for the LC-3b decode path. Takes a 16-bit IR plus
//  the incremented PC, extracts and sign/zero-extends the opcode's immediate to WORD_W bits, applies
//  the <<1 word scaling, and computes the PC-relative target. Sits between fetch/decode and the
//  execute latch. Uses a valid/ready handshake with backpressure and a flush.
// PARAMETERS
//  WORD_W      16  output datapath width; legal values 16..64; IR stays 16 bits
//  REL_ADD_EN  1   1: stage 2 computes out_target = pc + imm; 0: out_target tied to 0
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  flush       in   1       drop all in-flight entries (branch redirect)
//  in_valid    in   1       in_ir/in_pc valid this cycle
//  in_ready    out  1       stage 1 can accept a beat
//  in_ir       in   16      instruction word; opcode = in_ir[15:12]
//  in_pc       in   WORD_W  PC of the instruction + 2
//  out_valid   out  1       stage 2 holds a result
//  out_ready   in   1       consumer accepts the result
//  out_imm     out  WORD_W  extended/scaled immediate
//  out_use_imm out  1       the instruction consumes out_imm as an operand/offset
//  out_pc_rel  out  1       out_target is meaningful (BR, JSR imm, LEA)
//  out_target  out  WORD_W  pc + imm (modulo 2^WORD_W)
// BEHAVIOUR
//  Extraction (stage 1, combinational into s1 regs); sext = sign-extend to WORD_W:
//   ADD/AND 0001/0101: sext(ir[4:0]); use_imm = ir[5]
//   BR 0000, LEA 1110: sext(ir[8:0])<<1; use_imm=1; pc_rel=1
//   JSR 0100: ir[11]=1 -> sext(ir[10:0])<<1, use_imm=1, pc_rel=1; ir[11]=0 (JSRR) -> imm=0, use_imm=0
//   LDB/STB 0010/0011: sext(ir[5:0]), no shift; use_imm=1
//   LDR/STR/LDI/STI 0110/0111/1010/1011: sext(ir[5:0])<<1; use_imm=1
//   SHF 1101: zext(ir[3:0]); use_imm=1
//   TRAP 1111: zext(ir[7:0])<<1; use_imm=1
//   all other opcodes: imm=0, use_imm=0, pc_rel=0
//  Pipeline: s1 regs {valid, imm, pc, use_imm, pc_rel}; s2 regs are the outputs. Latency = 2 cycles
//   from accepted beat to out_valid when out_ready is held high; throughput = 1 per cycle.
//  Handshake: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
//   A beat transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
//   While out_valid & !out_ready, all out_* hold stable. in_ready drops only when both stages are full.
//   in_ready is combinational from out_ready; no other combinational in->out path.
//  pc_rel=0 or REL_ADD_EN=0 -> out_target = 0.
//  Flush: the next edge clears s1_valid and out_valid; a beat presented with flush is dropped.
//   in_ready = 1 during flush. An output handshake in the flush cycle still counts as consumed.
//   Flush has priority over new input.
//  Reset (asynchronous, any time incl. mid-stream): both valid bits = 0; out_imm, out_target = 0;
//   out_use_imm, out_pc_rel = 0. Data regs also clear. First accept possible on the first edge
//   after rst_n rises.
//  Width: shift is done after extension at WORD_W; the adder wraps silently, no carry out.
// STRUCTURE
//  lc3b_types: add lc3b_opcode enum (op_br..op_trap) and the IMM_*_MSB field constants; reuse lc3b_word.
//  Sub-module imm_extract (combinational, parametrised WORD_W): IR -> {imm, use_imm, pc_rel}.
//  imm_gen_pipe holds the two register stages, handshake, flush and target adder.
// TESTING
//  ADD IR=0x127F -> out_imm=0xFFFF, use_imm=1, 2 cycles after accept; IR=0x1242 -> use_imm=0
//  BR IR=0x0FFF, pc=0x3002 -> imm=0xFFFE, pc_rel=1, target=0x3000; TRAP IR=0xF025 -> imm=0x004A
//  Back-to-back 8 beats, out_ready low for 3 cycles mid-stream -> outputs stable, in_ready low only
//   when both stages full, no loss/duplication, order kept
//  flush with both stages full plus in_valid -> next cycle out_valid=0, s1 empty, dropped beat never emerges
//  rst_n low mid-stream -> out_valid=0 immediately (async), all outputs 0; resumes cleanly after release
//  WORD_W=32: LEA IR=0xE100, pc=0x00001000 -> imm=0xFFFFFE00, target=0x00000E00; SHF IR=0xDA4F -> imm=0x0000000F

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b decode types: the machine word, the 4-bit opcode encoding
//   and the MSB positions of every immediate/offset field in the IR.
//   No ports (package).
// ---------------------------------------------------------------------------
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   localparam int IMM_IMM5_MSB   = 4;   // ADD/AND imm5
   localparam int IMM_OFF6_MSB   = 5;   // LDB/STB/LDR/STR/LDI/STI offset6
   localparam int IMM_OFF9_MSB   = 8;   // BR/LEA PCoffset9
   localparam int IMM_OFF11_MSB  = 10;  // JSR PCoffset11
   localparam int IMM_TRAP8_MSB  = 7;   // TRAP trapvect8
   localparam int IMM_SHAMT4_MSB = 3;   // SHF amount4
   localparam int IMM_ADD_MODE   = 5;   // ir[5]: register vs immediate operand
   localparam int IMM_JSR_MODE   = 11;  // ir[11]: JSR (offset) vs JSRR (register)

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// ---------------------------------------------------------------------------
// imm_extract
//   Combinational IR decode: picks the immediate field for the opcode,
//   extends it to WORD_W bits and applies the <<1 word scaling where the
//   instruction addresses words.
//   ir_i      : 16-bit instruction word
//   imm_o     : extended/scaled immediate (WORD_W bits)
//   use_imm_o : instruction consumes imm_o
//   pc_rel_o  : imm_o is a PC-relative offset
// ---------------------------------------------------------------------------
module imm_extract
   import lc3b_types::*;
#(
   parameter int WORD_W = 16
) (
   input  lc3b_word          ir_i,
   output logic [WORD_W-1:0] imm_o,
   output logic              use_imm_o,
   output logic              pc_rel_o
);

   lc3b_opcode        op;
   logic [WORD_W-1:0] sext5, sext6, sext9, sext11, zext4, zext8;

   assign op = lc3b_opcode'(ir_i[15:12]);

   assign sext5  = {{(WORD_W-IMM_IMM5_MSB-1){ir_i[IMM_IMM5_MSB]}},   ir_i[IMM_IMM5_MSB:0]};
   assign sext6  = {{(WORD_W-IMM_OFF6_MSB-1){ir_i[IMM_OFF6_MSB]}},   ir_i[IMM_OFF6_MSB:0]};
   assign sext9  = {{(WORD_W-IMM_OFF9_MSB-1){ir_i[IMM_OFF9_MSB]}},   ir_i[IMM_OFF9_MSB:0]};
   assign sext11 = {{(WORD_W-IMM_OFF11_MSB-1){ir_i[IMM_OFF11_MSB]}}, ir_i[IMM_OFF11_MSB:0]};
   assign zext4  = {{(WORD_W-IMM_SHAMT4_MSB-1){1'b0}},               ir_i[IMM_SHAMT4_MSB:0]};
   assign zext8  = {{(WORD_W-IMM_TRAP8_MSB-1){1'b0}},                ir_i[IMM_TRAP8_MSB:0]};

   // Word scaling happens after extension so the sign bit lands at WORD_W-1.
   function automatic logic [WORD_W-1:0] scale2(input logic [WORD_W-1:0] v);
      return {v[WORD_W-2:0], 1'b0};
   endfunction

   always_comb begin
      imm_o     = '0;
      use_imm_o = 1'b0;
      pc_rel_o  = 1'b0;
      case (op)
         op_add, op_and: begin
            imm_o     = sext5;
            use_imm_o = ir_i[IMM_ADD_MODE];
         end
         op_br, op_lea: begin
            imm_o     = scale2(sext9);
            use_imm_o = 1'b1;
            pc_rel_o  = 1'b1;
         end
         op_jsr: begin
            // JSRR takes its target from a register: no immediate at all.
            if (ir_i[IMM_JSR_MODE]) begin
               imm_o     = scale2(sext11);
               use_imm_o = 1'b1;
               pc_rel_o  = 1'b1;
            end
         end
         op_ldb, op_stb: begin
            imm_o     = sext6;
            use_imm_o = 1'b1;
         end
         op_ldr, op_str, op_ldi, op_sti: begin
            imm_o     = scale2(sext6);
            use_imm_o = 1'b1;
         end
         op_shf: begin
            imm_o     = zext4;
            use_imm_o = 1'b1;
         end
         op_trap: begin
            imm_o     = scale2(zext8);
            use_imm_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Two-stage immediate/offset generator for the LC-3b decode path.
//   Stage 1 registers the decoded immediate and PC, stage 2 registers the
//   outputs together with the PC-relative target. Valid/ready handshake with
//   backpressure and a flush that empties both stages.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop everything in flight
//   in_valid/in_ready   : input handshake; in_ir (16b), in_pc (PC+2, WORD_W)
//   out_valid/out_ready : output handshake
//   out_imm             : extended/scaled immediate
//   out_use_imm         : instruction consumes out_imm
//   out_pc_rel          : out_target is meaningful
//   out_target          : pc + imm, wrapping at WORD_W bits (0 if not PC-rel)
// ---------------------------------------------------------------------------
module imm_gen_pipe
   import lc3b_types::*;
#(
   parameter int WORD_W     = 16,
   parameter bit REL_ADD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  lc3b_word          in_ir,
   input  logic [WORD_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_imm,
   output logic              out_use_imm,
   output logic              out_pc_rel,
   output logic [WORD_W-1:0] out_target
);

   logic [WORD_W-1:0] ext_imm;
   logic              ext_use_imm, ext_pc_rel;

   logic              vld_p1_q, vld_p1_d;
   logic [WORD_W-1:0] imm_p1_q, imm_p1_d, pc_p1_q, pc_p1_d;
   logic              use_imm_p1_q, use_imm_p1_d, pc_rel_p1_q, pc_rel_p1_d;

   logic              vld_p2_q, vld_p2_d;
   logic [WORD_W-1:0] imm_p2_q, imm_p2_d, tgt_p2_q, tgt_p2_d;
   logic              use_imm_p2_q, use_imm_p2_d, pc_rel_p2_q, pc_rel_p2_d;

   logic              s1_adv, s2_adv;
   logic [WORD_W-1:0] rel_target;

   imm_extract #(.WORD_W(WORD_W)) u_extract (
      .ir_i      (in_ir),
      .imm_o     (ext_imm),
      .use_imm_o (ext_use_imm),
      .pc_rel_o  (ext_pc_rel)
   );

   assign s2_adv   = !vld_p2_q || out_ready;
   assign s1_adv   = !vld_p1_q || s2_adv;
   assign in_ready = s1_adv || flush;

   // Non-relative instructions (or a build without the adder) report target 0.
   assign rel_target = (REL_ADD_EN && pc_rel_p1_q) ? (pc_p1_q + imm_p1_q) : '0;

   always_comb begin
      vld_p1_d     = vld_p1_q;
      imm_p1_d     = imm_p1_q;
      pc_p1_d      = pc_p1_q;
      use_imm_p1_d = use_imm_p1_q;
      pc_rel_p1_d  = pc_rel_p1_q;
      vld_p2_d     = vld_p2_q;
      imm_p2_d     = imm_p2_q;
      tgt_p2_d     = tgt_p2_q;
      use_imm_p2_d = use_imm_p2_q;
      pc_rel_p2_d  = pc_rel_p2_q;

      if (flush) begin
         // Flush wins over any new beat; data regs keep stale contents.
         vld_p1_d = 1'b0;
         vld_p2_d = 1'b0;
      end else begin
         if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
               imm_p2_d     = imm_p1_q;
               tgt_p2_d     = rel_target;
               use_imm_p2_d = use_imm_p1_q;
               pc_rel_p2_d  = pc_rel_p1_q;
            end
         end
         if (s1_adv) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
               imm_p1_d     = ext_imm;
               pc_p1_d      = in_pc;
               use_imm_p1_d = ext_use_imm;
               pc_rel_p1_d  = ext_pc_rel;
            end
         end
      end
   end

   // ---- stage 1: decoded immediate + PC ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q     <= 1'b0;
         imm_p1_q     <= '0;
         pc_p1_q      <= '0;
         use_imm_p1_q <= 1'b0;
         pc_rel_p1_q  <= 1'b0;
      end else begin
         vld_p1_q     <= vld_p1_d;
         imm_p1_q     <= imm_p1_d;
         pc_p1_q      <= pc_p1_d;
         use_imm_p1_q <= use_imm_p1_d;
         pc_rel_p1_q  <= pc_rel_p1_d;
      end
   end

   // ---- stage 2: output registers + target ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2_q     <= 1'b0;
         imm_p2_q     <= '0;
         tgt_p2_q     <= '0;
         use_imm_p2_q <= 1'b0;
         pc_rel_p2_q  <= 1'b0;
      end else begin
         vld_p2_q     <= vld_p2_d;
         imm_p2_q     <= imm_p2_d;
         tgt_p2_q     <= tgt_p2_d;
         use_imm_p2_q <= use_imm_p2_d;
         pc_rel_p2_q  <= pc_rel_p2_d;
      end
   end

   assign out_valid   = vld_p2_q;
   assign out_imm     = imm_p2_q;
   assign out_target  = tgt_p2_q;
   assign out_use_imm = use_imm_p2_q;
   assign out_pc_rel  = pc_rel_p2_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Scoreboard bench for imm_gen_pipe: a 16-bit instance, a 32-bit instance
//   and a 16-bit instance without the target adder, all driven in lockstep.
//   Accepted beats push hand-computed expectations; the monitor pops and
//   compares whenever an output handshake occurs.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] pc;
      logic [31:0] imm;
      logic        use_imm;
      logic        pc_rel;
      logic [15:0] t16;
      logic [31:0] t32;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_ir = '0;
   logic [15:0] in_pc = '0;
   logic [31:0] in_pc32;

   logic        rdy16, v16, use16, rel16;
   logic [15:0] imm16, tgt16;
   logic        rdy32, v32, use32, rel32;
   logic [31:0] imm32, tgt32;
   logic        rdyn, vn, usen, reln;
   logic [15:0] immn, tgtn;

   int checks = 0;
   int errors = 0;

   vec_t vecs[13];
   vec_t q[$];

   assign in_pc32 = {16'h0000, in_pc};

   always #5 clk = ~clk;

   imm_gen_pipe #(.WORD_W(16), .REL_ADD_EN(1'b1)) u16 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy16),
      .in_ir(in_ir), .in_pc(in_pc), .out_valid(v16), .out_ready(out_ready),
      .out_imm(imm16), .out_use_imm(use16), .out_pc_rel(rel16), .out_target(tgt16));

   imm_gen_pipe #(.WORD_W(32), .REL_ADD_EN(1'b1)) u32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_ir(in_ir), .in_pc(in_pc32), .out_valid(v32), .out_ready(out_ready),
      .out_imm(imm32), .out_use_imm(use32), .out_pc_rel(rel32), .out_target(tgt32));

   imm_gen_pipe #(.WORD_W(16), .REL_ADD_EN(1'b0)) un16 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdyn),
      .in_ir(in_ir), .in_pc(in_pc), .out_valid(vn), .out_ready(out_ready),
      .out_imm(immn), .out_use_imm(usen), .out_pc_rel(reln), .out_target(tgtn));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_v16"},   v16,   0);
      chk({tag, "_imm16"}, imm16, 0);
      chk({tag, "_tgt16"}, tgt16, 0);
      chk({tag, "_use16"}, use16, 0);
      chk({tag, "_rel16"}, rel16, 0);
      chk({tag, "_v32"},   v32,   0);
      chk({tag, "_imm32"}, imm32, 0);
      chk({tag, "_tgt32"}, tgt32, 0);
      chk({tag, "_vn"},    vn,    0);
   endtask

   // Present one beat; push its expectation on the edge that accepts it.
   task automatic send(input int idx);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_ir    = vecs[idx].ir;
      in_pc    = vecs[idx].pc;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = rdy16;
         @(posedge clk);
         if (acc) q.push_back(vecs[idx]);
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: vector %0d in_ready=%0b expected 1", idx, rdy16);
      end
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk(name, q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: handshake-driven scoreboard pop plus a per-cycle in_ready check.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready16", rdy16, (q.size() < 2) || out_ready || flush);
         chk("in_ready32", rdy32, (q.size() < 2) || out_ready || flush);
         if (v16) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got imm %0h ir-less beat, expected no output", imm16);
            end else begin
               chk("imm16",  imm16, q[0].imm[15:0]);
               chk("use16",  use16, q[0].use_imm);
               chk("rel16",  rel16, q[0].pc_rel);
               chk("tgt16",  tgt16, q[0].t16);
               chk("v32",    v32,   1);
               chk("imm32",  imm32, q[0].imm);
               chk("use32",  use32, q[0].use_imm);
               chk("rel32",  rel32, q[0].pc_rel);
               chk("tgt32",  tgt32, q[0].t32);
               chk("vn",     vn,    1);
               chk("immn",   immn,  q[0].imm[15:0]);
               chk("reln",   reln,  q[0].pc_rel);
               chk("tgtn",   tgtn,  0);
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //             ir        pc        imm           use   rel   t16       t32
      vecs[0]  = '{16'h127F, 16'h3000, 32'hFFFFFFFF, 1'b1, 1'b0, 16'h0000, 32'h00000000}; // ADD imm -1
      vecs[1]  = '{16'h1242, 16'h3000, 32'h00000002, 1'b0, 1'b0, 16'h0000, 32'h00000000}; // ADD reg
      vecs[2]  = '{16'h0FFF, 16'h3002, 32'hFFFFFFFE, 1'b1, 1'b1, 16'h3000, 32'h00003000}; // BR -1 word
      vecs[3]  = '{16'hF025, 16'h3000, 32'h0000004A, 1'b1, 1'b0, 16'h0000, 32'h00000000}; // TRAP x25
      vecs[4]  = '{16'h6283, 16'h3000, 32'h00000006, 1'b1, 1'b0, 16'h0000, 32'h00000000}; // LDR +3
      vecs[5]  = '{16'h2060, 16'h3000, 32'hFFFFFFE0, 1'b1, 1'b0, 16'h0000, 32'h00000000}; // LDB -32
      vecs[6]  = '{16'h4805, 16'h4000, 32'h0000000A, 1'b1, 1'b1, 16'h400A, 32'h0000400A}; // JSR +5
      vecs[7]  = '{16'h4080, 16'h4000, 32'h00000000, 1'b0, 1'b0, 16'h0000, 32'h00000000}; // JSRR
      vecs[8]  = '{16'hDA4F, 16'h3000, 32'h0000000F, 1'b1, 1'b0, 16'h0000, 32'h00000000}; // SHF 15
      vecs[9]  = '{16'hE100, 16'h1000, 32'hFFFFFE00, 1'b1, 1'b1, 16'h0E00, 32'h00000E00}; // LEA -256
      vecs[10] = '{16'h927F, 16'h3000, 32'h00000000, 1'b0, 1'b0, 16'h0000, 32'h00000000}; // NOT
      vecs[11] = '{16'h00FF, 16'hFF00, 32'h000001FE, 1'b1, 1'b1, 16'h00FE, 32'h000100FE}; // BR wrap
      vecs[12] = '{16'hB03F, 16'h3000, 32'hFFFFFFFE, 1'b1, 1'b0, 16'h0000, 32'h00000000}; // STI -1

      // Reset state
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Latency: accepted on edge k, out_valid after edge k+1
      send(0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_c1_valid", v16, 0);
      @(negedge clk);
      chk("latency_c2_valid", v16, 1);
      drain("drain_latency");

      // Every decode pattern, back to back
      for (int i = 1; i < 13; i++) send(i);
      in_valid = 1'b0;
      drain("drain_patterns");

      // Eight beats with a 3-cycle output stall mid-stream
      fork
         begin
            for (int i = 2; i < 10; i++) send(i);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("drain_stall");

      // Flush with both stages full and a beat offered
      out_ready = 1'b0;
      send(4);
      send(5);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_ir    = vecs[6].ir;
      in_pc    = vecs[6].pc;
      @(negedge clk);
      chk("flush_in_ready", rdy16, 1);
      @(posedge clk);
      q.delete();
      #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_v16_c1", v16, 0);
      chk("flush_v32_c1", v32, 0);
      @(negedge clk);
      chk("flush_v16_c2", v16, 0);
      drain("drain_flush");

      // Asynchronous reset mid-stream, then resume
      send(0);
      send(1);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1 chk_all_zero("midreset");
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(9);
      send(11);
      send(2);
      in_valid = 1'b0;
      drain("drain_resume");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
